// File: rtl/mem_tb_pkg.sv
// mem_tb_pkg: shared types and constants for the template-block memory read path
package mem_tb_pkg;
    localparam int NQ = 64;
    localparam int NP = 256;
    localparam int QW = 3;
    localparam int PW = 4;
    localparam logic [7:0] Q_LAST = 8'(NQ - 1);
    localparam logic [7:0] P_LAST = 8'(NP - 1);
    typedef enum logic [2:0] {IDLE, SWEEP_A, SWEEP_B, DRAIN, DONE} state_t;
    typedef struct packed {
        logic [1:0] bank;
        logic [5:0] word;
    } bank_addr_t;
    // raster {y,x} -> bank {y[0],x[0]}, word {y[3:1],x[3:1]}
    function automatic bank_addr_t raster_to_bank(input logic [2*PW-1:0] a);
        raster_to_bank.bank = {a[PW], a[0]};
        raster_to_bank.word = {a[2*PW-1:PW+1], a[PW-1:1]};
    endfunction
endpackage

// File: rtl/mem_tb_read_seq_rd_valid_pipe.sv
// rd_valid_pipe: delays {valid, tag} by the memory read latency, with synchronous flush
module rd_valid_pipe #(
    parameter int DEPTH = 1,
    parameter int TW = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_vld,
    input  logic [TW-1:0] in_tag,
    output logic          out_vld,
    output logic [TW-1:0] out_tag
);
    logic [TW:0] sr [DEPTH];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
        end else begin
            sr[0] <= {in_vld, in_vld ? in_tag : '0};
            for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
        end
    end
    assign {out_vld, out_tag} = sr[DEPTH-1];
endmodule

// File: rtl/mem_tb_read_seq.sv
// mem_tb_read_seq: sweeps all port-A quads then all port-B pixels, emitting latency-aligned valid/tag streams
module mem_tb_read_seq
    import mem_tb_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic          stall,
    output logic [5:0]    addr_a,
    output logic [7:0]    addr_b,
    output logic          vld_a,
    output logic [QW-1:0] qx,
    output logic [QW-1:0] qy,
    output logic          vld_b,
    output logic [PW-1:0] px,
    output logic [PW-1:0] py,
    output logic          busy,
    output logic          done
);
    localparam logic [7:0] D_LAST = 8'(RD_LAT - 1);
    state_t state;
    logic [7:0] cnt;
    logic iss_a, iss_b, flush;
    logic [2*QW-1:0] tag_a;
    logic [2*PW-1:0] tag_b;
    assign flush = abort && state != IDLE;
    assign iss_a = state == SWEEP_A && !stall && !abort;
    assign iss_b = state == SWEEP_B && !stall && !abort;
    assign {qy, qx} = tag_a;
    assign {py, px} = tag_b;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            addr_a <= '0;
            addr_b <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (iss_a) addr_a <= cnt[5:0];
            if (iss_b) addr_b <= cnt;
            if (flush) begin
                state <= IDLE;
                busy  <= 1'b0;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: if (start && !abort) begin
                        state <= SWEEP_A;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                    SWEEP_A: if (!stall) begin
                        cnt   <= cnt == Q_LAST ? '0 : cnt + 8'd1;
                        state <= cnt == Q_LAST ? SWEEP_B : SWEEP_A;
                    end
                    SWEEP_B: if (!stall) begin
                        cnt   <= cnt == P_LAST ? '0 : cnt + 8'd1;
                        state <= cnt == P_LAST ? DRAIN : SWEEP_B;
                    end
                    // stall is ignored: the last reads are already in flight
                    DRAIN: if (cnt == D_LAST) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                    DONE: state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end
    rd_valid_pipe #(.DEPTH(RD_LAT), .TW(2*QW)) u_pipe_a (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_vld(iss_a), .in_tag(cnt[5:0]),
        .out_vld(vld_a), .out_tag(tag_a)
    );
    rd_valid_pipe #(.DEPTH(RD_LAT), .TW(2*PW)) u_pipe_b (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_vld(iss_b), .in_tag(cnt),
        .out_vld(vld_b), .out_tag(tag_b)
    );
endmodule

// File: tb/tb_mem_tb_read_seq.sv
// tb_mem_tb_read_seq: scoreboard bench; the model expects 64 quads then 256 raster pixels, delayed by stalls
module tb_mem_tb_read_seq;
    import mem_tb_pkg::*;
    localparam int RD_LAT = 1;
    logic clk = 0, rst_n = 0, start = 0, abort = 0, stall = 0;
    logic [5:0] addr_a;
    logic [7:0] addr_b;
    logic vld_a, vld_b, busy, done;
    logic [2:0] qx, qy;
    logic [3:0] px, py;
    int checks = 0, passes = 0, cyc = 0;
    typedef struct { bit pb; int tag; int t; } ent_t;
    ent_t q[$];
    bit bsy = 0, mdone = 0;
    int m = 0, exp_done = -1;

    always #5 clk = ~clk;

    mem_tb_read_seq #(.RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .stall(stall),
        .addr_a(addr_a), .addr_b(addr_b), .vld_a(vld_a), .qx(qx), .qy(qy),
        .vld_b(vld_b), .px(px), .py(py), .busy(busy), .done(done)
    );

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    endtask

    // reference model: every non-stalled busy cycle issues the next item of the sweep
    initial begin
        ent_t e;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                q.delete(); bsy = 0; mdone = 0; m = 0; exp_done = -1;
            end else begin
                cyc++;
                if (mdone) begin
                    mdone = 0; exp_done = -1;
                end else if (!bsy) begin
                    if (start && !abort) begin bsy = 1; m = 0; end
                end else if (abort) begin
                    bsy = 0; q.delete(); exp_done = -1;
                end else begin
                    if (m < NQ + NP && !stall) begin
                        e.pb = m >= NQ;
                        e.tag = m < NQ ? m : m - NQ;
                        e.t = cyc + RD_LAT - 1;
                        q.push_back(e);
                        m++;
                        if (m == NQ + NP) exp_done = cyc + RD_LAT;
                    end
                    if (exp_done == cyc) begin bsy = 0; mdone = 1; end
                end
            end
        end
    end

    initial begin
        ent_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("busy", busy, bsy);
                chk("done", done, mdone);
                while (q.size() > 0 && q[0].t < cyc) begin
                    chk("missing_vld_expected_at", cyc, q[0].t);
                    void'(q.pop_front());
                end
                if (vld_a || vld_b) begin
                    if (q.size() == 0) chk("unexpected_vld", 1, 0);
                    else begin
                        e = q.pop_front();
                        chk("vld_both", vld_a && vld_b, 0);
                        chk("port", vld_b, e.pb);
                        chk("tag", vld_b ? {py, px} : {2'b0, qy, qx}, e.tag);
                        chk("vld_time", cyc, e.t);
                        if (vld_a) chk("addr_a", addr_a, {qy, qx});
                        else chk("addr_b", addr_b, {py, px});
                    end
                end
            end
        end
    end

    task automatic step(input bit s, input bit st, input bit ab);
        @(negedge clk);
        start = s; stall = st; abort = ab;
    endtask

    task automatic run_done(input int bound, input int exp_len, input int c0);
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (done) break;
        end
        chk("sweep_len", done ? cyc - c0 : -1, exp_len);
    endtask

    initial begin
        int c0;
        bit found;
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        chk("reset_outs", {addr_a, addr_b, vld_a, vld_b, qx, qy, px, py, busy, done}, 0);
        // plain sweep
        step(1, 0, 0); c0 = cyc; step(0, 0, 0);
        run_done(400, 322, c0);
        // stall five cycles after the 10th quad
        step(1, 0, 0); c0 = cyc;
        repeat (10) step(0, 0, 0);
        repeat (5) step(0, 1, 0);
        step(0, 0, 0);
        chk("addr_a_hold", addr_a, 9);
        run_done(400, 327, c0);
        // stalls around the port A -> port B handover
        step(1, 0, 0); c0 = cyc;
        repeat (63) step(0, 0, 0);
        repeat (2) step(0, 1, 0);
        step(0, 0, 0);
        repeat (2) step(0, 1, 0);
        step(0, 0, 0);
        run_done(400, 326, c0);
        // abort at pixel (y=2,x=3)
        step(1, 0, 0); step(0, 0, 0);
        found = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (vld_b && py == 2 && px == 3) begin found = 1; break; end
        end
        chk("abort_point_found", found, 1);
        abort = 1;
        @(negedge clk); abort = 0;
        chk("abort_vld_b", vld_b, 0);
        chk("abort_busy", busy, 0);
        repeat (5) step(0, 0, 0);
        step(1, 0, 0); c0 = cyc; step(0, 0, 0);
        run_done(400, 322, c0);
        // start pulses while sweeping are ignored
        step(1, 0, 0); c0 = cyc;
        repeat (5) step(0, 0, 0);
        step(1, 0, 0);
        repeat (20) step(0, 0, 0);
        step(1, 0, 0); step(0, 0, 0);
        run_done(400, 322, c0);
        // start with abort in IDLE is dropped
        step(1, 0, 1); step(0, 0, 0); step(0, 0, 0);
        chk("start_abort_busy", busy, 0);
        chk("start_abort_vld", vld_a, 0);
        // asynchronous reset mid sweep, off the clock edge
        step(1, 0, 0);
        repeat (20) step(0, 0, 0);
        #2 rst_n = 0;
        #1 chk("async_reset_outs", {addr_a, addr_b, vld_a, vld_b, qx, qy, px, py, busy, done}, 0);
        @(negedge clk); @(negedge clk); rst_n = 1;
        step(1, 0, 0); c0 = cyc; step(0, 0, 0);
        run_done(400, 322, c0);
        // random traffic
        for (int i = 0; i < 3000; i++)
            step($urandom_range(19) == 0, $urandom_range(5) == 0, $urandom_range(399) == 0);
        step(0, 0, 0);
        repeat (400) @(negedge clk);
        chk("queue_empty", q.size(), 0);
        chk("final_busy", busy, 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
